// File: rtl/parse_pkg.sv
// Shared constants and state type for the rejection-sampling parser.
package parse_pkg;

    localparam int                COEF_W         = 12;
    localparam logic [COEF_W-1:0] Q              = 12'hD01;
    localparam int                N_COEF_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/parse_check.sv
// Single-candidate range check: a 12-bit candidate is accepted iff it is below Q.
module parse_check
    import parse_pkg::*;
(
    input  logic [COEF_W-1:0] cand_i,
    output logic              accept_o
);

    assign accept_o = (cand_i < Q);

endmodule

// File: rtl/parse_ctrl.sv
// Rejection-sampling controller: splits 24-bit XOF words into two candidates and emits
// the accepted ones as an indexed coefficient stream. Optional stats: `PARSE_STATS_EN.
module parse_ctrl
    import parse_pkg::*;
#(
    parameter int N_COEF = N_COEF_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [23:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [COEF_W-1:0] coef,
    output logic [7:0]        coef_idx,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              busy,
    output logic              done
`ifdef PARSE_STATS_EN
    ,
    output logic [15:0]       reject_cnt
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(N_COEF - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [COEF_W-1:0] buf0_q, buf0_d;
    logic [COEF_W-1:0] buf1_q, buf1_d;
    logic [7:0]        idx_q, idx_d;

    logic [COEF_W-1:0] d1, d2;
    logic              acc1, acc2;
    logic [1:0]        n_acc;
    logic              in_hs, out_hs;

    assign d1 = in_data[11:0];
    assign d2 = in_data[23:12];

    parse_check u_check_d1 (
        .cand_i   (d1),
        .accept_o (acc1)
    );

    parse_check u_check_d2 (
        .cand_i   (d2),
        .accept_o (acc2)
    );

    assign n_acc = 2'(acc1) + 2'(acc2);

    assign in_ready   = (state_q == RUN) && (cnt_q == 2'd0);
    assign coef_valid = (state_q == RUN) && (cnt_q != 2'd0);
    assign coef       = buf0_q;
    assign coef_idx   = idx_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);

    assign in_hs  = in_valid && in_ready;
    assign out_hs = coef_valid && coef_ready;

`ifdef PARSE_STATS_EN
    logic [15:0] rej_q, rej_d;
    logic [1:0]  n_rej;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign n_rej      = 2'd2 - n_acc;
    assign reject_cnt = rej_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        idx_d   = idx_q;
`ifdef PARSE_STATS_EN
        rej_d   = rej_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                    buf0_d  = '0;
                    buf1_d  = '0;
                    idx_d   = '0;
`ifdef PARSE_STATS_EN
                    rej_d   = '0;
`endif
                end
            end
            RUN: begin
                // in_hs needs an empty buffer and out_hs a non-empty one, so they never coincide
                if (out_hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        cnt_d   = 2'd0;
                        buf0_d  = '0;
                        buf1_d  = '0;
                        idx_d   = '0;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = '0;
                        cnt_d  = cnt_q - 2'd1;
                        idx_d  = idx_q + 8'd1;
                    end
                end else if (in_hs) begin
                    buf0_d = acc1 ? d1 : d2;
                    buf1_d = (acc1 && acc2) ? d2 : '0;
                    cnt_d  = n_acc;
`ifdef PARSE_STATS_EN
                    rej_d  = sat_add16(rej_q, n_rej);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            idx_q   <= '0;
`ifdef PARSE_STATS_EN
            rej_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            idx_q   <= idx_d;
`ifdef PARSE_STATS_EN
            rej_q   <= rej_d;
`endif
        end
    end

endmodule

// File: tb/tb_parse_ctrl.sv
// Scenario bench for parse_ctrl with an expected-coefficient queue drained by a monitor.
module tb_parse_ctrl;

    localparam int          N     = 256;
    localparam logic [11:0] QMOD  = 12'hD01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] coef;
    logic [7:0]  coef_idx;
    logic        coef_valid;
    logic        coef_ready = 1'b1;
    logic        busy;
    logic        done;
`ifdef PARSE_STATS_EN
    logic [15:0] reject_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [19:0] exp_q[$];
    logic [19:0] exp_e;
    int          model_idx = 0;
    int          model_rej = 0;

    parse_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coef       (coef),
        .coef_idx   (coef_idx),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .busy       (busy),
        .done       (done)
`ifdef PARSE_STATS_EN
        ,
        .reject_cnt (reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every output handshake is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && coef_valid && coef_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL coef_stream: got coef=%h idx=%0d, expected no output", coef, coef_idx);
            end else begin
                exp_e = exp_q.pop_front();
                if ({coef, coef_idx} !== exp_e) begin
                    errors++;
                    $display("FAIL coef_stream: got coef=%h idx=%0d, expected coef=%h idx=%0d",
                             coef, coef_idx, exp_e[19:8], exp_e[7:0]);
                end
            end
        end
    end

    task automatic model_push(input logic [23:0] w);
        logic [11:0] c;
        for (int k = 0; k < 2; k++) begin
            c = (k == 0) ? w[11:0] : w[23:12];
            if (c < QMOD) begin
                if (model_idx < N) begin
                    exp_q.push_back({c, 8'(model_idx)});
                    model_idx++;
                end
            end else if (model_rej < 16'hFFFF) begin
                model_rej++;
            end
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_word_timeout: in_ready=%b, required 1", in_ready);
        end else begin
            model_push(w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_idx = 0;
        model_rej = 0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        coef_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_idx = 0;
        model_rej = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d coefficients outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_last_then_check_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(coef_valid && coef_idx == 8'd255) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(coef_valid && coef_idx == 8'd255) || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_last: valid=%b idx=%0d done=%b busy=%b, required 1/255/0/1",
                     name, coef_valid, coef_idx, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || coef_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b in_ready=%b valid=%b, required 1/0/0/0",
                     name, done, busy, in_ready, coef_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, coef_valid, coef, coef_idx, busy, done} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b coef=%h idx=%0d busy=%b done=%b, required all 0",
                     in_ready, coef_valid, coef, coef_idx, busy, done);
        end
`ifdef PARSE_STATS_EN
        checks++;
        if (reject_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_reject_cnt: got %0d, required 0", reject_cnt);
        end
`endif
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: busy=%b in_ready=%b, required 0/0", busy, in_ready);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL boundary_run_entry: busy=%b in_ready=%b done=%b, required 1/1/0",
                     busy, in_ready, done);
        end
        send_word(24'hD00_D01);
        @(negedge clk);
        checks++;
        if (coef_valid !== 1'b1 || coef !== 12'hD00 || coef_idx !== 8'd0) begin
            errors++;
            $display("FAIL boundary_latency: valid=%b coef=%h idx=%0d, required 1/d00/0",
                     coef_valid, coef, coef_idx);
        end
        wait_drain("boundary");
`ifdef PARSE_STATS_EN
        checks++;
        if (reject_cnt !== 16'(model_rej)) begin
            errors++;
            $display("FAIL boundary_reject_cnt: got %0d, required %0d", reject_cnt, model_rej);
        end
`endif
    endtask

    task automatic test_all_reject();
        do_reset();
        pulse_start();
        for (int w = 0; w < 3; w++) begin
            send_word(24'hFFF_FFF);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || coef_valid !== 1'b0) begin
                errors++;
                $display("FAIL all_reject_word%0d: in_ready=%b valid=%b, required 1/0",
                         w, in_ready, coef_valid);
            end
        end
`ifdef PARSE_STATS_EN
        checks++;
        if (reject_cnt !== 16'd6 || model_rej != 6) begin
            errors++;
            $display("FAIL all_reject_cnt: got %0d, required 6", reject_cnt);
        end
`endif
    endtask

    task automatic test_full_run();
        do_reset();
        pulse_start();
        for (int w = 0; w < 128; w++) send_word(24'h002_001);
        wait_last_then_check_done("full_run");
        wait_drain("full_run");
    endtask

    task automatic test_drop_surplus();
        do_reset();
        pulse_start();
        send_word(24'hFFF_005);
        for (int w = 0; w < 128; w++) send_word(24'h002_001);
        wait_last_then_check_done("drop");
        wait_drain("drop");
`ifdef PARSE_STATS_EN
        checks++;
        if (reject_cnt !== 16'd1) begin
            errors++;
            $display("FAIL drop_reject_cnt: got %0d, required 1", reject_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        pulse_start();
        coef_ready = 1'b0;
        send_word(24'h123_456);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (coef_valid !== 1'b1 || coef !== 12'h456 || coef_idx !== 8'd0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: valid=%b coef=%h idx=%0d in_ready=%b, required 1/456/0/0",
                         c, coef_valid, coef, coef_idx, in_ready);
            end
        end
        @(posedge clk);
        #1;
        coef_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (coef_valid !== 1'b1 || coef !== 12'h123 || coef_idx !== 8'd1) begin
            errors++;
            $display("FAIL backpressure_second: valid=%b coef=%h idx=%0d, required 1/123/1",
                     coef_valid, coef, coef_idx);
        end
        @(negedge clk);
        checks++;
        if (coef_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_drained: valid=%b in_ready=%b, required 0/1",
                     coef_valid, in_ready);
        end
        wait_drain("backpressure");
    endtask

    task automatic test_reset_midrun();
        do_reset();
        pulse_start();
        for (int w = 0; w < 51; w++) send_word(24'h002_001);
        checks++;
        if (coef_valid !== 1'b1 || coef_idx !== 8'd100) begin
            errors++;
            $display("FAIL midrun_idx: valid=%b idx=%0d, required 1/100", coef_valid, coef_idx);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({in_ready, coef_valid, coef, coef_idx, busy, done} !== 24'h0) begin
            errors++;
            $display("FAIL midrun_reset: rdy=%b vld=%b coef=%h idx=%0d busy=%b done=%b, required all 0",
                     in_ready, coef_valid, coef, coef_idx, busy, done);
        end
        @(posedge clk);
        #1;
        pulse_start();
        send_word(24'h002_001);
        @(negedge clk);
        checks++;
        if (coef_valid !== 1'b1 || coef_idx !== 8'd0 || coef !== 12'h001) begin
            errors++;
            $display("FAIL midrun_restart: valid=%b coef=%h idx=%0d, required 1/001/0",
                     coef_valid, coef, coef_idx);
        end
        wait_drain("restart");
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_all_reject();
        test_full_run();
        test_drop_surplus();
        test_backpressure();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
